// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 set-2 key sequencing controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXT   = 2'd1,
    BRK   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] BAT_FAIL  = 8'hFC;
  localparam logic [7:0] KBD_ERR0  = 8'h00;
  localparam logic [7:0] KBD_ERR1  = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // 00 and FF are keyboard-reported error/overrun codes
  function automatic logic is_kbd_err(input logic [7:0] b);
    return (b == KBD_ERR0) || (b == KBD_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO holding completed key events.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // a pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign dout    = (count != '0) ? mem[rd_ptr] : '0;

  // pointers wrap naturally; the extra count bit separates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; the output is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns raw set-2 scan-code bytes into complete key events with status and error tracking.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [19:0] TIMEOUT = 20'd500000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_done,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       inhibit,
  output logic       bat_ok,
  output logic [2:0] err,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] INH_LEVEL = (AW+1)'(DEPTH-1);

  state_t      state;
  state_t      state_next;
  logic        ext;
  logic        ext_next;
  logic [2:0]  pcnt;
  logic [2:0]  pcnt_next;
  logic [19:0] tcnt;
  logic        timeout_hit;

  logic        push;
  event_t      push_ev;
  logic        set_kbd;
  logic        set_seq;
  logic        set_ovf;
  logic        bat_set;
  logic        bat_clr;

  logic        fifo_full;
  logic [AW:0] fifo_count;
  logic [9:0]  fifo_dout;

  assign timeout_hit = (state != IDLE) && (tcnt == TIMEOUT);
  assign ev_valid    = (fifo_count != '0);
  assign ev_data     = fifo_dout;
  assign set_ovf     = push && fifo_full && !(ev_valid && ev_ready);

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk   (sysclk),
    .rst   (reset),
    .push  (push),
    .pop   (ev_ready),
    .din   (push_ev),
    .full  (fifo_full),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  // sequence state register together with the held ext flag and pause byte counter
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ext   <= 1'b0;
      pcnt  <= 3'd0;
    end else begin
      state <= state_next;
      ext   <= ext_next;
      pcnt  <= pcnt_next;
    end
  end

  // prefix decoding: decides the next state, any event to push and any flags to raise
  always_comb begin
    state_next = state;
    ext_next   = ext;
    pcnt_next  = pcnt;
    push       = 1'b0;
    push_ev    = '0;
    set_kbd    = 1'b0;
    set_seq    = 1'b0;
    bat_set    = 1'b0;
    bat_clr    = 1'b0;

    if (rx_done) begin
      case (state)
        IDLE: begin
          case (rx_byte)
            PFX_EXT: begin
              state_next = EXT;
              ext_next   = 1'b0;
            end
            PFX_BRK: begin
              state_next = BRK;
              ext_next   = 1'b0;
            end
            PFX_PAUSE: begin
              state_next = PAUSE;
              pcnt_next  = 3'd7;
            end
            BAT_OK:   bat_set = 1'b1;
            BAT_FAIL: begin
              bat_clr = 1'b1;
              set_kbd = 1'b1;
            end
            KBD_ERR0, KBD_ERR1: set_kbd = 1'b1;
            default: begin
              push    = 1'b1;
              push_ev = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
            end
          endcase
        end
        EXT: begin
          if (rx_byte == PFX_BRK) begin
            state_next = BRK;
            ext_next   = 1'b1;
          end else if (is_kbd_err(rx_byte)) begin
            set_kbd    = 1'b1;
            state_next = IDLE;
          end else if (rx_byte == PFX_EXT || rx_byte == PFX_PAUSE) begin
            set_seq    = 1'b1;
            state_next = IDLE;
          end else begin
            push       = 1'b1;
            push_ev    = '{ext: 1'b1, brk: 1'b0, code: rx_byte};
            state_next = IDLE;
          end
        end
        BRK: begin
          state_next = IDLE;
          if (is_kbd_err(rx_byte)) begin
            set_kbd = 1'b1;
          end else if (rx_byte == PFX_EXT || rx_byte == PFX_PAUSE || rx_byte == PFX_BRK) begin
            set_seq = 1'b1;
          end else begin
            push    = 1'b1;
            push_ev = '{ext: ext, brk: 1'b1, code: rx_byte};
          end
        end
        PAUSE: begin
          if (pcnt <= 3'd1) begin
            push       = 1'b1;
            push_ev    = '{ext: 1'b1, brk: 1'b0, code: PFX_PAUSE};
            pcnt_next  = 3'd0;
            state_next = IDLE;
          end else begin
            pcnt_next = pcnt - 3'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      set_seq    = 1'b1;
      state_next = IDLE;
    end

    if (state_next == IDLE) begin
      ext_next  = 1'b0;
      pcnt_next = 3'd0;
    end
  end

  // inter-byte timer: runs only while a multi-byte sequence is open
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (rx_done || state_next == IDLE) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 20'd1;
    end
  end

  // sticky error flags; a fresh error in the clearing cycle survives the clear
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      err <= 3'b000;
    end else begin
      err <= (err_clr ? 3'b000 : err) | {set_ovf, set_kbd, set_seq};
    end
  end

  // self-test status and the registered flow-control request
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bat_ok  <= 1'b0;
      inhibit <= 1'b0;
    end else begin
      if (bat_set)      bat_ok <= 1'b1;
      else if (bat_clr) bat_ok <= 1'b0;
      inhibit <= (fifo_count >= INH_LEVEL);
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: directed scenarios followed by a randomized byte stream.
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [19:0] TMO   = 20'd500;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_done = 1'b0;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic       inhibit;
  logic       bat_ok;
  logic [2:0] err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] exp_q[$];
  logic [7:0] seq[$];
  int         pause_left = 0;
  logic [2:0] exp_err = 3'b000;
  logic       exp_bat = 1'b0;
  logic       pend_valid = 1'b0;
  logic [9:0] pend_ev = 10'h000;
  int         occ = 0;
  bit         rdy_random = 1'b0;

  ps2_key_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .ev_data  (ev_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .inhibit  (inhibit),
    .bat_ok   (bat_ok),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // interprets the byte against the pending prefix sequence and records any completed event
  function automatic void modelByte(input logic [7:0] b);
    logic is_err;
    is_err = (b == 8'h00) || (b == 8'hFF);
    if (seq.size() == 0) begin
      if (b == PFX_EXT || b == PFX_BRK) seq.push_back(b);
      else if (b == PFX_PAUSE) begin
        seq.push_back(b);
        pause_left = 7;
      end
      else if (b == BAT_OK) exp_bat = 1'b1;
      else if (b == BAT_FAIL) begin
        exp_bat    = 1'b0;
        exp_err[1] = 1'b1;
      end
      else if (is_err) exp_err[1] = 1'b1;
      else begin
        pend_valid = 1'b1;
        pend_ev    = {2'b00, b};
      end
    end else if (seq[0] == PFX_PAUSE) begin
      pause_left--;
      if (pause_left == 0) begin
        pend_valid = 1'b1;
        pend_ev    = 10'h2E1;
        seq.delete();
      end
    end else if (seq[seq.size()-1] == PFX_BRK) begin
      if (is_err) exp_err[1] = 1'b1;
      else if (b == PFX_EXT || b == PFX_PAUSE || b == PFX_BRK) exp_err[0] = 1'b1;
      else begin
        pend_valid = 1'b1;
        pend_ev    = {(seq[0] == PFX_EXT), 1'b1, b};
      end
      seq.delete();
    end else begin
      if (b == PFX_BRK) seq.push_back(b);
      else begin
        if (is_err) exp_err[1] = 1'b1;
        else if (b == PFX_EXT || b == PFX_PAUSE) exp_err[0] = 1'b1;
        else begin
          pend_valid = 1'b1;
          pend_ev    = {2'b10, b};
        end
        seq.delete();
      end
    end
  endfunction

  function automatic void modelTimeout();
    if (seq.size() != 0) exp_err[0] = 1'b1;
    seq.delete();
  endfunction

  // buffer model: accepts the pending event if there is room (or a pop frees some)
  always @(posedge sysclk) begin
    bit pop_acc;
    if (!reset) begin
      pop_acc = (occ > 0) && (ev_ready === 1'b1);
      if (pend_valid) begin
        if (occ < DEPTH || pop_acc) begin
          exp_q.push_back(pend_ev);
          occ = occ + 1;
        end else begin
          exp_err[2] = 1'b1;
        end
        pend_valid = 1'b0;
      end
      if (pop_acc) occ = occ - 1;
    end
  end

  // random consumer readiness when enabled
  always @(posedge sysclk) begin
    #1;
    if (rdy_random) ev_ready = 1'($urandom_range(0, 1));
  end

  // monitor: head event must match the scoreboard; consumed on handshake
  always @(negedge sysclk) begin
    if (!reset && ev_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got %h expected none", ev_data);
      end else begin
        checkOutput("ev_data", 32'(ev_data), 32'(exp_q[0]));
        if (ev_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge sysclk);
    #1;
    rx_byte = b;
    rx_done = 1'b1;
    modelByte(b);
    @(posedge sysclk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic clearErrors();
    err_clr = 1'b1;
    exp_err = 3'b000;
    idleCycles(1);
    err_clr = 1'b0;
  endtask

  task automatic doReset();
    @(posedge sysclk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    seq.delete();
    occ        = 0;
    pend_valid = 1'b0;
    exp_err    = 3'b000;
    exp_bat    = 1'b0;
    pause_left = 0;
    #1;
    checkOutput("rst_ev_valid", 32'(ev_valid), 0);
    checkOutput("rst_ev_data", 32'(ev_data), 0);
    checkOutput("rst_inhibit", 32'(inhibit), 0);
    checkOutput("rst_bat_ok", 32'(bat_ok), 0);
    checkOutput("rst_err", 32'(err), 0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    ev_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge sysclk);
      n++;
    end
    #1;
    checkOutput(name, 32'(exp_q.size()), 0);
    idleCycles(2);
    checkOutput({name, "_valid_low"}, 32'(ev_valid), 0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    doReset();

    // make and break, one-cycle latency
    ev_ready = 1'b1;
    applyStimulus(8'h1C);
    checkOutput("make_valid", 32'(ev_valid), 1);
    checkOutput("make_data", 32'(ev_data), 32'h01C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("break_valid", 32'(ev_valid), 1);
    checkOutput("break_data", 32'(ev_data), 32'h11C);
    idleCycles(3);

    // extended make and break
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("ext_break_data", 32'(ev_data), 32'h375);
    idleCycles(3);
    applyStimulus(8'hE0);
    applyStimulus(8'h74);
    checkOutput("ext_make_data", 32'(ev_data), 32'h274);
    idleCycles(3);
    checkOutput("ext_err", 32'(err), 0);

    // pause sequence yields one event
    for (int i = 0; i < 8; i++) begin
      applyStimulus(pause_seq[i]);
      if (i == 3) checkOutput("pause_quiet", 32'(ev_valid), 0);
    end
    checkOutput("pause_valid", 32'(ev_valid), 1);
    checkOutput("pause_data", 32'(ev_data), 32'h2E1);
    drain("pause_drain");

    // backpressure, inhibit and overflow
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h10 + 8'(i));
      if (i == 6) begin
        checkOutput("inhibit_before", 32'(inhibit), 0);
        idleCycles(1);
        checkOutput("inhibit_after", 32'(inhibit), 1);
      end
    end
    checkOutput("ovf_err", 32'(err), 32'h4);
    checkOutput("ovf_model", 32'(err), 32'(exp_err));
    drain("bp_drain");
    checkOutput("inhibit_released", 32'(inhibit), 0);
    clearErrors();

    // status and error codes
    applyStimulus(8'hAA);
    idleCycles(1);
    checkOutput("bat_ok", 32'(bat_ok), 1);
    checkOutput("bat_no_event", 32'(ev_valid), 0);
    applyStimulus(8'hFF);
    checkOutput("kbd_err", 32'(err), 32'h2);
    clearErrors();
    checkOutput("err_clr", 32'(err), 0);
    applyStimulus(8'hE0);
    idleCycles(int'(TMO) + 100);
    modelTimeout();
    checkOutput("timeout_err", 32'(err), 32'h1);
    applyStimulus(8'h1C);
    checkOutput("after_timeout_data", 32'(ev_data), 32'h01C);
    idleCycles(2);
    clearErrors();
    checkOutput("err_clr2", 32'(err), 0);

    // reset in the middle of a sequence
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    doReset();
    applyStimulus(8'h75);
    checkOutput("post_reset_data", 32'(ev_data), 32'h075);
    checkOutput("post_reset_bat", 32'(bat_ok), 0);
    idleCycles(3);

    // randomized byte stream with random consumer readiness
    rdy_random = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'hE0;
      else if (r < 14) b = 8'hF0;
      else if (r < 16) b = 8'hE1;
      else if (r < 17) b = 8'hAA;
      else if (r < 18) b = 8'hFC;
      else if (r < 19) b = 8'h00;
      else if (r < 20) b = 8'hFF;
      else             b = 8'($urandom_range(1, 8'h83));
      applyStimulus(b);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end
    rdy_random = 1'b0;
    idleCycles(1);
    drain("rand_drain");
    checkOutput("rand_err", 32'(err), 32'(exp_err));
    checkOutput("rand_bat", 32'(bat_ok), 32'(exp_bat));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard bound on total run time
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
